data_compare_serial: RTL and testbench
======================================

// Module: data_compare_serial
// PURPOSE
//   Multi-cycle magnitude comparator for wide operands. Generalises the 8-bit combinational comparator.
//   Compares WIDTH-bit iData_a vs iData_b, CHUNK bits per cycle, MSB chunk first.
//   Supports signed/unsigned mode and optional early exit on the first differing chunk.
//   Start/busy/done handshake. Sits between register-file/ALU-side producers and branch/sort logic
//   that need wide compares without a WIDTH-bit combinational carry chain.
// PARAMETERS
//   WIDTH      32  operand width; must be a multiple of CHUNK (elaboration error otherwise)
//   CHUNK       8  bits compared per cycle; NCHUNK = WIDTH/CHUNK >= 1
//   EARLY_EXIT  1  1: finish on first differing chunk; 0: always scan all NCHUNK chunks (constant latency)
// PORTS
//   iClk     in   1      clock, rising edge
//   iRst     in   1      synchronous reset, active-high
//   iStart   in   1      start request; sampled only when oBusy=0
//   iSigned  in   1      1: two's-complement compare; 0: unsigned; latched with iStart
//   iData_a  in   WIDTH  operand a; latched with iStart
//   iData_b  in   WIDTH  operand b; latched with iStart
//   oBusy    out  1      high while a compare is in progress
//   oDone    out  1      one-cycle pulse: oData holds a new result
//   oData    out  3      result {gt,eq,lt}: 100 a>b, 010 a==b, 001 a<b, 000 no result yet
// BEHAVIOUR
//   Reset: oBusy=0, oDone=0, oData=000, FSM->IDLE. Applies in any state; an in-flight compare is discarded.
//   FSM IDLE -> RUN -> DONE -> IDLE.
//   IDLE: iStart=1 at an edge -> latch a, b and iSigned; idx=NCHUNK-1; go RUN; oBusy=1 from the next cycle.
//   RUN: each cycle compare chunk idx of a vs b, unsigned, and register the outcome.
//   - Signed mode: invert bit WIDTH-1 of both operands before comparing (applies to top chunk only).
//   - Chunk differs, first difference: record gt/lt. If EARLY_EXIT=1 -> go DONE.
//   - If EARLY_EXIT=0, keep scanning; later chunks never overwrite the recorded result.
//   - Chunk equal and idx>0: idx--, stay RUN.
//   - idx==0 processed: go DONE; result = eq if no difference was recorded.
//   DONE: one cycle. oDone=1, oBusy=0, oData=final result. Returns to IDLE.
//   oData holds its value until the next oDone; it is never 000 after the first result.
//   Latency: k = chunks examined (1..NCHUNK; k=NCHUNK when EARLY_EXIT=0 or when a==b).
//   - oDone is high exactly k+1 cycles after the edge that sampled iStart.
//   iStart while oBusy=1: ignored, with no effect on the latched operands.
//   iStart during the DONE cycle: accepted (back-to-back). The next compare begins RUN the following cycle.
//   iData_a/iData_b/iSigned may change freely after the start edge; only latched copies are used.
//   NCHUNK=1: single RUN cycle; behaves as a registered comparator with 2-cycle latency.
//   Index counter width: $clog2(NCHUNK), minimum 1 bit; no wrap beyond 0.
// STRUCTURE
//   Package data_compare_pkg:
//   - Result constants CMP_NONE=3'b000, CMP_GT=3'b100, CMP_EQ=3'b010, CMP_LT=3'b001.
//   - State typedef cmp_state_t {IDLE,RUN,DONE}.
//   Sub-module data_compare_chunk (parameter CHUNK):
//   - Combinational unsigned CHUNK-bit compare -> {gt,eq,lt}; instantiated once, fed by a chunk mux on idx.
//   Top: operand/mode latches, idx counter, FSM, result register.
// TESTING  (WIDTH=32, CHUNK=8 unless noted)
//   1. EARLY_EXIT=1, unsigned, a=32'h0000_0001, b=32'h0000_0000
//      -> chunks scan to idx 0; oDone at start+5; oData=100.
//   2. EARLY_EXIT=1, unsigned, a=32'hF000_0000, b=32'hF100_0000
//      -> top chunk differs; oDone at start+2; oData=001.
//   3. Signed, a=32'hFFFF_FFFF (-1), b=32'h0000_0001
//      -> oData=001. Same operands unsigned -> 100.
//   4. EARLY_EXIT=0, a=b=32'hDEAD_BEEF -> oData=010 at start+5.
//      Then a=32'h1000_0000, b=0 -> oData=100 still at start+5.
//   5. iStart held high continuously with changing operands -> accepted only in IDLE/DONE cycles.
//      Results match the operands present at each accepted edge; mid-RUN operand changes are ignored.
//   6. iRst asserted in RUN idx=2
//      -> next cycle oBusy=0, oDone=0, oData=000; no oDone pulse follows; a fresh start then completes normally.

Source files
------------

// File: rtl/data_compare_pkg.sv
// rtl/data_compare_pkg.sv - result codes and FSM states for the serial wide-operand comparator
package data_compare_pkg;

    localparam logic [2:0] CMP_NONE = 3'b000;
    localparam logic [2:0] CMP_GT   = 3'b100;
    localparam logic [2:0] CMP_EQ   = 3'b010;
    localparam logic [2:0] CMP_LT   = 3'b001;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } cmp_state_t;

endpackage

// File: rtl/data_compare_serial_if.sv
// rtl/data_compare_serial_if.sv - start/busy/done compare bus between producer and comparator
interface data_compare_serial_if #(
    parameter int WIDTH = 32
) ();

    logic             iStart;
    logic             iSigned;
    logic [WIDTH-1:0] iData_a;
    logic [WIDTH-1:0] iData_b;
    logic             oBusy;
    logic             oDone;
    logic [2:0]       oData;

    modport master (
        output iStart, iSigned, iData_a, iData_b,
        input  oBusy, oDone, oData
    );

    modport slave (
        input  iStart, iSigned, iData_a, iData_b,
        output oBusy, oDone, oData
    );

endinterface

// File: rtl/data_compare_chunk.sv
// rtl/data_compare_chunk.sv - combinational unsigned CHUNK-bit compare producing {gt,eq,lt}
module data_compare_chunk
    import data_compare_pkg::*;
#(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] iA,
    input  logic [CHUNK-1:0] iB,
    output logic [2:0]       oRes
);

    always_comb begin
        oRes = CMP_EQ;
        if (iA > iB) begin
            oRes = CMP_GT;
        end else if (iA < iB) begin
            oRes = CMP_LT;
        end
    end

endmodule

// File: rtl/data_compare_serial.sv
// rtl/data_compare_serial.sv - multi-cycle magnitude comparator, MSB chunk first, optional early exit
module data_compare_serial
    import data_compare_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int CHUNK      = 8,
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic                  iClk,
    input  logic                  iRst,
    data_compare_serial_if.slave  bus
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDXW-1:0]  IDX_TOP   = IDXW'(NCHUNK - 1);
    localparam logic [WIDTH-1:0] SIGN_MASK = WIDTH'(1) << (WIDTH - 1);

    generate
        if ((WIDTH % CHUNK) != 0 || NCHUNK < 1) begin : gBadWidth
            $error("data_compare_serial: WIDTH must be a non-zero multiple of CHUNK");
        end
    endgenerate

    cmp_state_t       state;
    cmp_state_t       stateNext;
    logic [WIDTH-1:0] aReg;
    logic [WIDTH-1:0] bReg;
    logic [IDXW-1:0]  idx;
    logic             found;
    logic [2:0]       recorded;
    logic [2:0]       dataReg;
    logic [CHUNK-1:0] aChunk;
    logic [CHUNK-1:0] bChunk;
    logic [2:0]       chunkRes;
    logic             chunkDiff;
    logic             lastChunk;
    logic             finish;
    logic             accept;
    logic             busy;
    logic             done;

    // Signed order equals unsigned order once both sign bits are flipped, so
    // the flip is applied at latch time and the datapath stays unsigned.
    assign aChunk = aReg[int'(idx)*CHUNK +: CHUNK];
    assign bChunk = bReg[int'(idx)*CHUNK +: CHUNK];

    data_compare_chunk #(
        .CHUNK (CHUNK)
    ) uChunk (
        .iA   (aChunk),
        .iB   (bChunk),
        .oRes (chunkRes)
    );

    assign chunkDiff = (chunkRes != CMP_EQ);
    assign lastChunk = (idx == '0);
    assign finish    = lastChunk || (EARLY_EXIT && chunkDiff);

    always_comb begin
        stateNext = state;
        busy      = 1'b0;
        done      = 1'b0;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.iStart) begin
                    accept    = 1'b1;
                    stateNext = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (finish) begin
                    stateNext = DONE;
                end
            end
            DONE: begin
                done = 1'b1;
                if (bus.iStart) begin
                    accept    = 1'b1;
                    stateNext = RUN;
                end else begin
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state    <= IDLE;
            aReg     <= '0;
            bReg     <= '0;
            idx      <= IDX_TOP;
            found    <= 1'b0;
            recorded <= CMP_NONE;
            dataReg  <= CMP_NONE;
        end else begin
            state <= stateNext;
            if (accept) begin
                aReg  <= bus.iData_a ^ (bus.iSigned ? SIGN_MASK : '0);
                bReg  <= bus.iData_b ^ (bus.iSigned ? SIGN_MASK : '0);
                idx   <= IDX_TOP;
                found <= 1'b0;
            end else if (state == RUN) begin
                // Only the most significant difference decides the outcome.
                if (!found && chunkDiff) begin
                    found    <= 1'b1;
                    recorded <= chunkRes;
                end
                if (!lastChunk) begin
                    idx <= idx - 1'b1;
                end
                if (finish) begin
                    dataReg <= found ? recorded : chunkRes;
                end
            end
        end
    end

    assign bus.oBusy = busy;
    assign bus.oDone = done;
    assign bus.oData = dataReg;

endmodule

// File: tb/tb_data_compare_serial.sv
// tb/tb_data_compare_serial.sv - randomized and directed bench for data_compare_serial
module tb_data_compare_serial;
    import data_compare_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        sgn = 1'b0;
    logic [31:0] da = '0;
    logic [31:0] db = '0;

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    data_compare_serial_if #(.WIDTH(32)) ifE1 ();
    data_compare_serial_if #(.WIDTH(32)) ifE0 ();
    data_compare_serial_if #(.WIDTH(32)) ifN1 ();

    assign ifE1.iStart = start;  assign ifE1.iSigned = sgn;
    assign ifE1.iData_a = da;    assign ifE1.iData_b = db;
    assign ifE0.iStart = start;  assign ifE0.iSigned = sgn;
    assign ifE0.iData_a = da;    assign ifE0.iData_b = db;
    assign ifN1.iStart = start;  assign ifN1.iSigned = sgn;
    assign ifN1.iData_a = da;    assign ifN1.iData_b = db;

    data_compare_serial #(.WIDTH(32), .CHUNK(8), .EARLY_EXIT(1'b1)) dutE1 (
        .iClk(clk), .iRst(rst), .bus(ifE1.slave));
    data_compare_serial #(.WIDTH(32), .CHUNK(8), .EARLY_EXIT(1'b0)) dutE0 (
        .iClk(clk), .iRst(rst), .bus(ifE0.slave));
    data_compare_serial #(.WIDTH(32), .CHUNK(32), .EARLY_EXIT(1'b1)) dutN1 (
        .iClk(clk), .iRst(rst), .bus(ifN1.slave));

    logic       busyV [3];
    logic       doneV [3];
    logic [2:0] dataV [3];
    assign busyV[0] = ifE1.oBusy;  assign doneV[0] = ifE1.oDone;  assign dataV[0] = ifE1.oData;
    assign busyV[1] = ifE0.oBusy;  assign doneV[1] = ifE0.oDone;  assign dataV[1] = ifE0.oData;
    assign busyV[2] = ifN1.oBusy;  assign doneV[2] = ifN1.oDone;  assign dataV[2] = ifN1.oData;

    function automatic int chunkOf(input int d);
        return (d == 2) ? 32 : 8;
    endfunction

    function automatic bit earlyOf(input int d);
        return d != 1;
    endfunction

    // Chunks examined: all of them unless early exit stops at the chunk holding the top differing bit.
    function automatic int expLat(input logic [31:0] a, input logic [31:0] b, input int chunk, input bit ee);
        int msb = -1;
        logic [31:0] x = a ^ b;
        for (int i = 0; i < 32; i++) if (x[i]) msb = i;
        if (!ee || msb < 0) return 32 / chunk;
        return 32 / chunk - msb / chunk;
    endfunction

    function automatic logic [2:0] expRes(input logic [31:0] a, input logic [31:0] b, input bit s);
        if (a == b) return CMP_EQ;
        if (s) return ($signed(a) > $signed(b)) ? CMP_GT : CMP_LT;
        return (a > b) ? CMP_GT : CMP_LT;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    bit         expBusy [3];
    bit         expDone [3];
    logic [2:0] expData [3];
    logic [2:0] pendRes [3];
    int         left    [3];
    bit         modelValid = 1'b0;

    // Model: cycles are counted per accepted compare, k RUN cycles then one DONE cycle.
    always @(posedge clk) begin
        if (rst) begin
            modelValid <= 1'b1;
            for (int d = 0; d < 3; d++) begin
                expBusy[d] <= 1'b0;
                expDone[d] <= 1'b0;
                expData[d] <= CMP_NONE;
                left[d]    <= 0;
            end
        end else begin
            for (int d = 0; d < 3; d++) begin
                if (expBusy[d]) begin
                    if (left[d] == 1) begin
                        expBusy[d] <= 1'b0;
                        expDone[d] <= 1'b1;
                        expData[d] <= pendRes[d];
                        left[d]    <= 0;
                    end else begin
                        left[d]    <= left[d] - 1;
                        expDone[d] <= 1'b0;
                    end
                end else begin
                    expDone[d] <= 1'b0;
                    if (start) begin
                        expBusy[d] <= 1'b1;
                        left[d]    <= expLat(da, db, chunkOf(d), earlyOf(d));
                        pendRes[d] <= expRes(da, db, sgn);
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (modelValid) begin
            for (int d = 0; d < 3; d++) begin
                check($sformatf("busy%0d", d), 32'(busyV[d]), 32'(expBusy[d]));
                check($sformatf("done%0d", d), 32'(doneV[d]), 32'(expDone[d]));
                check($sformatf("data%0d", d), 32'(dataV[d]), 32'(expData[d]));
            end
        end
    end

    task automatic directed(input string name, input logic [31:0] a, input logic [31:0] b, input bit s,
                            input logic [2:0] expD, input int l0, input int l1, input int l2);
        int lat  [3];
        int want [3];
        want[0] = l0; want[1] = l1; want[2] = l2;
        for (int d = 0; d < 3; d++) lat[d] = 0;
        @(negedge clk);
        start = 1'b1; da = a; db = b; sgn = s;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (i == 1) begin
                start = 1'b0; da = $urandom; db = $urandom; sgn = 1'($urandom);
            end
            for (int d = 0; d < 3; d++) begin
                if (lat[d] == 0 && doneV[d] === 1'b1) begin
                    lat[d] = i;
                    check($sformatf("%s_data%0d", name, d), 32'(dataV[d]), 32'(expD));
                end
            end
        end
        for (int d = 0; d < 3; d++) check($sformatf("%s_lat%0d", name, d), lat[d], want[d]);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int d = 0; d < 3; d++) check($sformatf("reset_data%0d", d), 32'(dataV[d]), 32'(CMP_NONE));

        directed("t1",  32'h0000_0001, 32'h0000_0000, 1'b0, CMP_GT, 5, 5, 2);
        directed("t2",  32'hF000_0000, 32'hF100_0000, 1'b0, CMP_LT, 2, 5, 2);
        directed("t3s", 32'hFFFF_FFFF, 32'h0000_0001, 1'b1, CMP_LT, 2, 5, 2);
        directed("t3u", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, CMP_GT, 2, 5, 2);
        directed("t4e", 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, CMP_EQ, 5, 5, 2);
        directed("t4g", 32'h1000_0000, 32'h0000_0000, 1'b0, CMP_GT, 2, 5, 2);
        directed("t4s", 32'h8000_0000, 32'h7FFF_FFFF, 1'b1, CMP_LT, 2, 5, 2);

        // Start held high with operands changing every cycle.
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            start = 1'b1; da = $urandom; db = (i % 3 == 0) ? da : da ^ (32'h1 << $urandom_range(0, 31));
            sgn = 1'($urandom);
        end
        start = 1'b0;
        repeat (8) @(negedge clk);

        // Reset while dutE1 is examining chunk idx 2.
        start = 1'b1; da = 32'h1234_5678; db = 32'h1234_5678; sgn = 1'b0;
        @(negedge clk); start = 1'b0;
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        check("rst_busy", 32'(busyV[0]), 32'h0);
        check("rst_done", 32'(doneV[0]), 32'h0);
        check("rst_data", 32'(dataV[0]), 32'(CMP_NONE));
        repeat (10) @(negedge clk);
        directed("t6", 32'h0000_0001, 32'h0000_0000, 1'b0, CMP_GT, 5, 5, 2);

        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            start = ($urandom_range(0, 3) == 0);
            sgn   = 1'($urandom);
            da    = $urandom;
            case ($urandom_range(0, 3))
                0:       db = da;
                1:       db = da ^ (32'h1 << $urandom_range(0, 31));
                2:       db = {da[31:16], 16'($urandom)};
                default: db = $urandom;
            endcase
        end
        start = 1'b0;
        repeat (10) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
